// File: rtl/selector_sequencer.sv
// selector_sequencer
//   Bus-mapped scheduler for a 4-way input selector. A schedule of up to four
//   slots (channel mask + dwell time) is played out on the registered one-hot
//   select, optionally looping. While idle the select follows the MANUAL
//   register, so the block also works as a plain static mux.
//
// Ports
//   clk, resetn         system clock, synchronous active-low reset
//   valid / ready       CPU bus handshake; ready pulses 1 cycle after valid
//   wstrb, addr, wdata  byte strobes (0 = read), byte address, write data
//   rdata               registered read data, valid while ready=1
//   in0..in3            selectable inputs
//   out                 selected input, lowest set bit of sel wins, 0 if sel==0
//   sel                 registered one-hot select mask
//   irq                 1-cycle pulse when a non-looping schedule completes
//
// Register map (addr[4:2])
//   0 CTRL    [0] run, [1] loop, [5:4] last slot index
//   1 STATUS  [0] busy, [5:4] current slot (RO); [8] done (W1C)
//   2 MANUAL  [3:0] select mask used while idle
//   4..7 SLOTk [DWELL_W-1:0] dwell, [19:16] channel mask
module selector_sequencer #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        in0,
  input  logic        in1,
  input  logic        in2,
  input  logic        in3,
  output logic        out,
  output logic [3:0]  sel,
  output logic        irq
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q;
  logic               ready_q;
  logic [31:0]        rdata_q;
  logic               irq_q;
  logic [3:0]         sel_q;

  logic               run_q;
  logic               loop_q;
  logic [1:0]         last_q;
  logic               done_q;
  logic [3:0]         manual_q;
  logic [DWELL_W-1:0] dwell_q [4];
  logic [3:0]         mask_q  [4];

  logic [1:0]         slot_q;
  logic [DWELL_W-1:0] cnt_q;

  // Bus decode
  logic               access;
  logic               is_write;
  logic               is_read;
  logic [2:0]         reg_idx;
  logic [1:0]         slot_idx;
  logic               wr_ctrl;
  logic               wr_status;
  logic               wr_manual;
  logic               wr_slot;
  logic [31:0]        wmask;
  logic [3:0]         manual_next;
  logic [DWELL_W-1:0] dwell_wr;
  logic [3:0]         mask_wr;
  logic [31:0]        rd_word;
  logic [1:0]         slot_inc;

  // Dwell counter reload: a zero dwell still occupies one cycle.
  function automatic logic [DWELL_W-1:0] load_cnt(input logic [DWELL_W-1:0] dwell);
    return (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  endfunction

  always_comb begin
    access    = valid & ~ready_q;
    is_write  = access & (|wstrb);
    is_read   = access & ~(|wstrb);
    reg_idx   = addr[4:2];
    slot_idx  = addr[3:2];
    wr_ctrl   = is_write & (reg_idx == 3'd0) & wstrb[0];
    wr_status = is_write & (reg_idx == 3'd1) & wstrb[1];
    wr_manual = is_write & (reg_idx == 3'd2) & wstrb[0];
    wr_slot   = is_write & reg_idx[2];
    slot_inc  = slot_q + 2'd1;

    wmask = '0;
    for (int k = 0; k < 4; k++) begin
      wmask[8*k +: 8] = {8{wstrb[k]}};
    end

    manual_next = wr_manual ? wdata[3:0] : manual_q;
    dwell_wr    = (dwell_q[slot_idx] & ~wmask[DWELL_W-1:0]) |
                  (wdata[DWELL_W-1:0] & wmask[DWELL_W-1:0]);
    mask_wr     = (mask_q[slot_idx] & ~wmask[19:16]) | (wdata[19:16] & wmask[19:16]);
  end

  // Read mux works on pre-edge register values.
  always_comb begin
    rd_word = '0;
    case (reg_idx)
      3'd0: begin
        rd_word[0]   = run_q;
        rd_word[1]   = loop_q;
        rd_word[5:4] = last_q;
      end
      3'd1: begin
        rd_word[0]   = (state_q == StRun);
        rd_word[5:4] = slot_q;
        rd_word[8]   = done_q;
      end
      3'd2: rd_word[3:0] = manual_q;
      3'd4, 3'd5, 3'd6, 3'd7: begin
        rd_word[DWELL_W-1:0] = dwell_q[slot_idx];
        rd_word[19:16]       = mask_q[slot_idx];
      end
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      sel_q    <= '0;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      last_q   <= '0;
      done_q   <= 1'b0;
      manual_q <= '0;
      slot_q   <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        dwell_q[i] <= '0;
        mask_q[i]  <= '0;
      end
    end else begin
      ready_q <= access;
      rdata_q <= is_read ? rd_word : '0;
      irq_q   <= 1'b0;

      // Register writes. The sequencer below keeps using the pre-edge values,
      // so new slot/last settings only matter from the next slot load.
      if (wr_manual) manual_q <= wdata[3:0];
      if (wr_slot) begin
        dwell_q[slot_idx] <= dwell_wr;
        mask_q[slot_idx]  <= mask_wr;
      end
      if (wr_ctrl) begin
        loop_q <= wdata[1];
        last_q <= wdata[5:4];
      end
      if (wr_status && wdata[8]) done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          sel_q  <= manual_next;
          slot_q <= '0;
          cnt_q  <= '0;
          if (wr_ctrl && wdata[0]) begin
            state_q <= StRun;
            run_q   <= 1'b1;
            sel_q   <= mask_q[0];
            cnt_q   <= load_cnt(dwell_q[0]);
          end
        end
        StRun: begin
          if (wr_ctrl && !wdata[0]) begin
            // Abort: straight back to idle, no done/irq.
            state_q <= StIdle;
            run_q   <= 1'b0;
            sel_q   <= manual_next;
            slot_q  <= '0;
            cnt_q   <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else if (slot_q < last_q) begin
            slot_q <= slot_inc;
            sel_q  <= mask_q[slot_inc];
            cnt_q  <= load_cnt(dwell_q[slot_inc]);
          end else if (loop_q) begin
            slot_q <= '0;
            sel_q  <= mask_q[0];
            cnt_q  <= load_cnt(dwell_q[0]);
          end else begin
            // Placed after the W1C clear so a same-cycle set wins.
            state_q <= StIdle;
            run_q   <= 1'b0;
            done_q  <= 1'b1;
            irq_q   <= 1'b1;
            sel_q   <= manual_next;
            slot_q  <= '0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Lowest set bit of sel picks the input.
  always_comb begin
    if (sel_q[0])      out = in0;
    else if (sel_q[1]) out = in1;
    else if (sel_q[2]) out = in2;
    else if (sel_q[3]) out = in3;
    else               out = 1'b0;
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign sel   = sel_q;
  assign irq   = irq_q;

  logic unused_sigs;
  assign unused_sigs = ^{addr[31:5], addr[1:0], wdata[31:20], wmask[31:20]};

endmodule

// File: tb/tb_selector_sequencer.sv
module tb_selector_sequencer;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        in0, in1, in2, in3;
  logic        out;
  logic [3:0]  sel;
  logic        irq;

  selector_sequencer #(.DWELL_W(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .valid  (valid),
    .ready  (ready),
    .wstrb  (wstrb),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .in0    (in0),
    .in1    (in1),
    .in2    (in2),
    .in3    (in3),
    .out    (out),
    .sel    (sel),
    .irq    (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: register file as plain words, schedule as
  // "cycles left in the current slot".
  logic [31:0] m_reg [8];
  logic [31:0] m_old [8];
  bit          m_busy, m_done, m_irq, m_ready;
  int          m_slot, m_left;
  logic [3:0]  m_sel;
  logic [31:0] m_rdata;

  function automatic logic [31:0] m_read(input int idx);
    logic [31:0] w;
    w = '0;
    if (idx == 1) begin
      w[0]   = m_busy;
      w[5:4] = 2'(m_slot);
      w[8]   = m_done;
    end else if (idx != 3) begin
      w = m_reg[idx];
    end
    return w;
  endfunction

  task automatic m_enter(input int s);
    m_slot = s;
    m_sel  = m_old[4+s][19:16];
    m_left = (m_old[4+s][15:0] == 16'd0) ? 1 : int'(m_old[4+s][15:0]);
  endtask

  task automatic model_step();
    bit acc, wr, ctrl_wr;
    int idx;
    logic [31:0] keep, bm;
    if (!resetn) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_busy = 0; m_done = 0; m_irq = 0; m_ready = 0;
      m_slot = 0; m_left = 0; m_sel = '0; m_rdata = '0;
      return;
    end
    for (int i = 0; i < 8; i++) m_old[i] = m_reg[i];
    acc     = valid && !m_ready;
    idx     = int'(addr[4:2]);
    m_rdata = (acc && wstrb == 4'd0) ? m_read(idx) : 32'd0;
    m_ready = acc;
    m_irq   = 0;
    wr      = acc && (wstrb != 4'd0);
    if (wr) begin
      keep = (idx == 0) ? 32'h33 : (idx == 2) ? 32'hF : (idx >= 4) ? 32'h000F_FFFF : 32'h0;
      bm = '0;
      for (int k = 0; k < 4; k++) if (wstrb[k]) bm[8*k +: 8] = 8'hFF;
      m_reg[idx] = (m_reg[idx] & ~(bm & keep)) | (wdata & bm & keep);
      if (idx == 1 && wstrb[1] && wdata[8]) m_done = 0;
    end
    ctrl_wr = wr && (idx == 0) && wstrb[0];
    if (m_busy) begin
      if (ctrl_wr && !wdata[0]) begin
        m_busy = 0;
        m_slot = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_slot < int'(m_old[0][5:4])) m_enter(m_slot + 1);
          else if (m_old[0][1]) m_enter(0);
          else begin
            m_busy = 0; m_slot = 0; m_done = 1; m_irq = 1;
            m_reg[0][0] = 1'b0;
          end
        end
      end
    end else if (ctrl_wr && wdata[0]) begin
      m_busy = 1;
      m_enter(0);
    end
    if (!m_busy) m_sel = m_reg[2][3:0];
  endtask

  function automatic logic exp_out(input logic [3:0] s);
    logic [3:0] v;
    v = {in3, in2, in1, in0};
    for (int k = 0; k < 4; k++) if (s[k]) return v[k];
    return 1'b0;
  endfunction

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("ready", {31'd0, ready}, {31'd0, m_ready});
    check("rdata", rdata, m_rdata);
    check("sel",   {28'd0, sel}, {28'd0, m_sel});
    check("out",   {31'd0, out}, {31'd0, exp_out(m_sel)});
    check("irq",   {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] rd, output int lat);
    valid = 1'b1; addr = a; wdata = wd; wstrb = st;
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (!ready && lat < 8);
    if (!ready) begin
      n_cmp++; n_err++;
      $display("FAIL bus_timeout addr %h: no ready after %0d cycles", a, lat);
    end
    rd = rdata;
    valid = 1'b0; wstrb = 4'd0; wdata = '0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] rexp;
  } vec_t;

  vec_t vecs [11];

  logic [3:0] t3_sel [7] = '{4'h1, 4'h1, 4'h1, 4'h4, 4'h4, 4'h6, 4'h6};
  logic       t3_irq [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0] t4_pat [5] = '{4'h1, 4'h1, 4'h1, 4'h4, 4'h4};

  initial begin
    logic [31:0] rd, wd, a;
    logic [3:0]  st;
    int lat, r;

    vecs[0]  = '{32'h08,  32'hFFFF_FFF6, 4'h1, 32'h0000_0006};
    vecs[1]  = '{32'h10,  32'hFFFF_FFFF, 4'hF, 32'h000F_FFFF};
    vecs[2]  = '{32'h14,  32'h1234_5678, 4'h3, 32'h0000_5678};
    vecs[3]  = '{32'h14,  32'h00AB_0000, 4'h4, 32'h000B_5678};
    vecs[4]  = '{32'h14,  32'hFFFF_00FF, 4'h2, 32'h000B_0078};
    vecs[5]  = '{32'h0C,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[6]  = '{32'h04,  32'hFFFF_FEFF, 4'hF, 32'h0000_0000};
    vecs[7]  = '{32'h00,  32'hFFFF_FFFE, 4'h1, 32'h0000_0032};
    vecs[8]  = '{32'h00,  32'h0000_0000, 4'hE, 32'h0000_0032};
    vecs[9]  = '{32'h108, 32'h0000_0009, 4'h1, 32'h0000_0009};
    vecs[10] = '{32'h1C,  32'h0000_0000, 4'h0, 32'h0000_0000};

    resetn = 1'b0; valid = 1'b0; wstrb = '0; addr = '0; wdata = '0;
    in0 = 1'b1; in1 = 1'b1; in2 = 1'b1; in3 = 1'b1;
    cycle(); cycle();
    resetn = 1'b1;
    cycle();

    // Reset state: every register reads 0, select idle, out 0 with all inputs high.
    check("rst_sel", {28'd0, sel}, 32'd0);
    check("rst_out", {31'd0, out}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus(32'(i * 4), 32'd0, 4'd0, rd, lat);
      check("rst_read", rd, 32'd0);
    end

    // Register table: write then read back.
    foreach (vecs[i]) begin
      bus(vecs[i].a, vecs[i].wd, vecs[i].st, rd, lat);
      bus(vecs[i].a, 32'd0, 4'd0, rd, lat);
      check("table_read", rd, vecs[i].rexp);
    end

    resetn = 1'b0; cycle(); resetn = 1'b1; cycle();

    // Manual select, lowest-bit priority, ack latency.
    in0 = 1'b1; in1 = 1'b1; in2 = 1'b0; in3 = 1'b1;
    bus(32'h08, 32'h6, 4'h1, rd, lat);
    check("manual_lat", 32'(lat), 32'd1);
    check("manual_sel", {28'd0, sel}, 32'h6);
    check("manual_out_in1", {31'd0, out}, 32'd1);
    in1 = 1'b0; in2 = 1'b1;
    cycle();
    check("manual_out_prio", {31'd0, out}, 32'd0);

    // Two-slot one-shot schedule.
    bus(32'h10, 32'h0001_0003, 4'hF, rd, lat);
    bus(32'h14, 32'h0004_0002, 4'hF, rd, lat);
    bus(32'h00, 32'h0000_0011, 4'h1, rd, lat);
    for (int i = 0; i < 7; i++) begin
      check("oneshot_sel", {28'd0, sel}, {28'd0, t3_sel[i]});
      check("oneshot_irq", {31'd0, irq}, {31'd0, t3_irq[i]});
      if (i < 6) cycle();
    end
    bus(32'h04, 32'd0, 4'd0, rd, lat);
    check("oneshot_status", rd, 32'h100);
    bus(32'h00, 32'd0, 4'd0, rd, lat);
    check("oneshot_ctrl", rd, 32'h10);

    // Looping schedule then abort.
    bus(32'h04, 32'h100, 4'h2, rd, lat);
    bus(32'h04, 32'd0, 4'd0, rd, lat);
    check("w1c_clear", rd, 32'd0);
    bus(32'h00, 32'h0000_0013, 4'h1, rd, lat);
    for (int i = 0; i < 20; i++) begin
      check("loop_sel", {28'd0, sel}, {28'd0, t4_pat[i % 5]});
      check("loop_irq", {31'd0, irq}, 32'd0);
      if (i < 19) cycle();
    end
    bus(32'h00, 32'h0000_0012, 4'h1, rd, lat);
    check("abort_sel", {28'd0, sel}, 32'h6);
    for (int i = 0; i < 3; i++) begin
      check("abort_irq", {31'd0, irq}, 32'd0);
      cycle();
    end
    bus(32'h04, 32'd0, 4'd0, rd, lat);
    check("abort_status", rd, 32'd0);

    // Zero dwell: exactly one cycle.
    bus(32'h10, 32'h0008_0000, 4'hF, rd, lat);
    bus(32'h00, 32'h0000_0001, 4'h1, rd, lat);
    check("dwell0_sel", {28'd0, sel}, 32'h8);
    cycle();
    check("dwell0_sel_after", {28'd0, sel}, 32'h6);
    check("dwell0_irq", {31'd0, irq}, 32'd1);
    bus(32'h04, 32'd0, 4'd0, rd, lat);
    check("dwell0_status", rd, 32'h100);
    bus(32'h04, 32'h100, 4'hF, rd, lat);

    // W1C landing on the same edge as done being set.
    bus(32'h10, 32'h0002_0003, 4'hF, rd, lat);
    bus(32'h00, 32'h0000_0001, 4'h1, rd, lat);
    cycle(); cycle();
    bus(32'h04, 32'h100, 4'hF, rd, lat);
    check("race_irq", {31'd0, irq}, 32'd1);
    bus(32'h04, 32'd0, 4'd0, rd, lat);
    check("race_done_kept", rd, 32'h100);
    bus(32'h04, 32'h100, 4'h2, rd, lat);
    bus(32'h04, 32'd0, 4'd0, rd, lat);
    check("race_done_cleared", rd, 32'd0);

    // Reset in the middle of a looping run.
    bus(32'h00, 32'h0000_0013, 4'h1, rd, lat);
    cycle(); cycle();
    resetn = 1'b0;
    cycle();
    check("midrst_sel", {28'd0, sel}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    resetn = 1'b1;
    cycle();
    bus(32'h00, 32'd0, 4'd0, rd, lat);
    check("midrst_ctrl", rd, 32'd0);
    bus(32'h10, 32'd0, 4'd0, rd, lat);
    check("midrst_slot0", rd, 32'd0);

    // Random traffic against the model.
    for (int it = 0; it < 600; it++) begin
      in0 = 1'($urandom); in1 = 1'($urandom); in2 = 1'($urandom); in3 = 1'($urandom);
      r = int'($urandom_range(0, 9));
      wd = $urandom;
      st = 4'($urandom_range(1, 15));
      case (r)
        0, 1: begin
          a = 32'h10 + 32'($urandom_range(0, 3) * 4);
          wd[15:0] = 16'($urandom_range(0, 5));
          bus(a, wd, st, rd, lat);
        end
        2: begin
          wd[0] = ($urandom_range(0, 3) != 0);
          bus(32'h00, wd, st, rd, lat);
        end
        3: bus(32'h04, wd, st, rd, lat);
        4: bus(($urandom_range(0, 1) != 0) ? 32'h08 : 32'h0C, wd, st, rd, lat);
        5, 6: begin
          a = $urandom;
          bus(a, 32'd0, 4'd0, rd, lat);
        end
        default: begin
          for (int k = 0; k < int'($urandom_range(1, 6)); k++) cycle();
        end
      endcase
      if ($urandom_range(0, 99) == 0) begin
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
      end
    end
    cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
